conv_window_ctrl: RTL and testbench



---
 rtl/sdc_conv_pkg.sv | 14 +
 rtl/wrap_counter.sv | 24 ++
 rtl/conv_window_ctrl.sv | 101 ++++++++++
 tb/tb_conv_window_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sdc_conv_pkg.sv
// sdc_conv_pkg: shared state encoding, layer defaults and window-count helper for conv window control
package sdc_conv_pkg;

   typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

   localparam int IMG_W_DEF = 28;
   localparam int IMG_H_DEF = 28;
   localparam int K_DEF     = 3;

   function automatic int win_count(input int w, input int h, input int k, input int s);
      return ((w - k) / s + 1) * ((h - k) / s + 1);
   endfunction

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: modulo-MAX counter with clear priority; wrap pulses on the enabled step out of MAX-1
module wrap_counter #(
   parameter int MAX = 2,
   localparam int W = MAX > 1 ? $clog2(MAX) : 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         wrap
);

   logic at_max;

   assign at_max = count == W'(MAX - 1);
   assign wrap   = en && at_max;

   always_ff @(posedge clk) begin
      if (reset || clear) count <= '0;
      else if (en) count <= at_max ? '0 : count + W'(1);
   end

endmodule

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: sequences KxK line-buffer shifting and flags stride-aligned valid windows
module conv_window_ctrl
   import sdc_conv_pkg::*;
#(
   parameter int IMG_W  = IMG_W_DEF,
   parameter int IMG_H  = IMG_H_DEF,
   parameter int K      = K_DEF,
   parameter int STRIDE = 1,
   parameter int CW     = $clog2(IMG_W),
   parameter int RW     = $clog2(IMG_H)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          out_ready,
   output logic          shift_en,
   output logic          win_valid,
   output logic [CW-1:0] out_col,
   output logic [RW-1:0] out_row,
   output logic          frame_done,
   output logic          busy
);

   localparam int SW = STRIDE > 1 ? $clog2(STRIDE) : 1;

   state_t        state;
   logic          clear, col_wrap, last_pix, col_in, row_in, emit_row, win;
   logic          unused_cph_wrap, unused_rph_wrap;
   logic [CW-1:0] col, ocnt;
   logic [RW-1:0] row, orow;
   logic [SW-1:0] cph, rph;

   assign in_ready = (state == FILL || state == RUN) && out_ready;
   assign shift_en = in_valid && in_ready;
   assign busy     = state != IDLE;
   assign clear    = state == IDLE && start;
   assign col_in   = col >= CW'(K - 1);
   assign row_in   = row >= RW'(K - 1);
   assign emit_row = row_in && rph == '0;
   assign win      = shift_en && col_in && emit_row && cph == '0;

   wrap_counter #(.MAX(IMG_W)) u_col (
      .clk(clk), .reset(reset), .clear(clear), .en(shift_en), .count(col), .wrap(col_wrap)
   );

   // row wraps only on the final pixel, which doubles as the end-of-frame event
   wrap_counter #(.MAX(IMG_H)) u_row (
      .clk(clk), .reset(reset), .clear(clear), .en(col_wrap), .count(row), .wrap(last_pix)
   );

   // stride phases stay at 0 until the window origin is reached, so no divider is needed
   wrap_counter #(.MAX(STRIDE)) u_cph (
      .clk(clk), .reset(reset), .clear(clear || col_wrap), .en(shift_en && col_in),
      .count(cph), .wrap(unused_cph_wrap)
   );

   wrap_counter #(.MAX(STRIDE)) u_rph (
      .clk(clk), .reset(reset), .clear(clear), .en(col_wrap && row_in),
      .count(rph), .wrap(unused_rph_wrap)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         win_valid  <= 1'b0;
         out_col    <= '0;
         out_row    <= '0;
         frame_done <= 1'b0;
         ocnt       <= '0;
         orow       <= '0;
      end else begin
         win_valid  <= win;
         frame_done <= 1'b0;
         if (win) begin
            out_col <= ocnt;
            out_row <= orow;
         end
         ocnt <= (clear || col_wrap) ? '0 : win ? ocnt + CW'(1) : ocnt;
         orow <= clear ? '0 : (col_wrap && emit_row) ? orow + RW'(1) : orow;
         case (state)
            IDLE: if (start) state <= FILL;
            FILL: begin
               if (last_pix) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
               end else if (shift_en && col == CW'(K - 1) && row == RW'(K - 1)) state <= RUN;
            end
            RUN: begin
               if (last_pix) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl: three configurations on shared stimulus, checked cycle by cycle against a frame-level model
module tb_conv_window_ctrl;

   logic clk = 1'b0;
   logic reset, start, in_valid, out_ready;
   logic [2:0] in_ready, shift_en, win_valid, frame_done, busy;
   logic [4:0] oc_a, or_a, oc_b, or_b;
   logic [1:0] oc_c, or_c;

   always #5 clk = ~clk;

   conv_window_ctrl #(.IMG_W(28), .IMG_H(28), .K(3), .STRIDE(1)) u_a (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready[0]),
      .out_ready(out_ready), .shift_en(shift_en[0]), .win_valid(win_valid[0]), .out_col(oc_a),
      .out_row(or_a), .frame_done(frame_done[0]), .busy(busy[0])
   );

   conv_window_ctrl #(.IMG_W(28), .IMG_H(28), .K(3), .STRIDE(2)) u_b (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready[1]),
      .out_ready(out_ready), .shift_en(shift_en[1]), .win_valid(win_valid[1]), .out_col(oc_b),
      .out_row(or_b), .frame_done(frame_done[1]), .busy(busy[1])
   );

   conv_window_ctrl #(.IMG_W(4), .IMG_H(3), .K(3), .STRIDE(1)) u_c (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready[2]),
      .out_ready(out_ready), .shift_en(shift_en[2]), .win_valid(win_valid[2]), .out_col(oc_c),
      .out_row(or_c), .frame_done(frame_done[2]), .busy(busy[2])
   );

   int checks = 0, errors = 0;
   int pw[3] = '{28, 28, 4};
   int ph[3] = '{28, 28, 3};
   int pk[3] = '{3, 3, 3};
   int ps[3] = '{1, 2, 1};
   int m[3], n[3], eoc[3], eor[3], wins[3], done_cnt[3];
   bit ew[3];
   bit mon_en = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // model state m: 0 idle, 1 taking pixels, 2 end-of-frame cycle
   task automatic step(input int d, input logic ir, input logic sh, input logic wv, input logic fd,
                       input logic bz, input logic [31:0] oc, input logic [31:0] orr);
      int c, r, tot;
      bit acc;
      string t;
      t   = $sformatf("u%0d", d);
      tot = ((pw[d] - pk[d]) / ps[d] + 1) * ((ph[d] - pk[d]) / ps[d] + 1);
      acc = in_valid && out_ready && m[d] == 1;
      check({t, ".busy"}, bz, m[d] != 0);
      check({t, ".in_ready"}, ir, m[d] == 1 && out_ready);
      check({t, ".shift_en"}, sh, acc);
      check({t, ".frame_done"}, fd, m[d] == 2);
      check({t, ".win_valid"}, wv, ew[d]);
      check({t, ".out_col"}, oc, eoc[d]);
      check({t, ".out_row"}, orr, eor[d]);
      if (wv === 1'b1) wins[d]++;
      if (fd === 1'b1) done_cnt[d]++;
      if (m[d] == 2) check({t, ".win_count"}, wins[d], tot);
      if (reset) begin
         m[d] = 0; n[d] = 0; ew[d] = 0; eoc[d] = 0; eor[d] = 0; wins[d] = 0;
      end else begin
         ew[d] = 0;
         if (acc) begin
            c = n[d] % pw[d];
            r = n[d] / pw[d];
            if (c >= pk[d] - 1 && r >= pk[d] - 1 && (c - pk[d] + 1) % ps[d] == 0 && (r - pk[d] + 1) % ps[d] == 0) begin
               ew[d]  = 1;
               eoc[d] = (c - pk[d] + 1) / ps[d];
               eor[d] = (r - pk[d] + 1) / ps[d];
            end
            n[d]++;
         end
         if (m[d] == 0 && start) begin
            m[d] = 1; n[d] = 0; wins[d] = 0;
         end else if (m[d] == 1 && acc && n[d] == pw[d] * ph[d]) m[d] = 2;
         else if (m[d] == 2) m[d] = 0;
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         step(0, in_ready[0], shift_en[0], win_valid[0], frame_done[0], busy[0], 32'(oc_a), 32'(or_a));
         step(1, in_ready[1], shift_en[1], win_valid[1], frame_done[1], busy[1], 32'(oc_b), 32'(or_b));
         step(2, in_ready[2], shift_en[2], win_valid[2], frame_done[2], busy[2], 32'(oc_c), 32'(or_c));
      end
   end

   task automatic cyc(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic wait_state(input int st, input int lim, input bit rnd);
      for (int i = 0; i < lim && m[0] != st; i++) begin
         if (rnd) begin
            in_valid  = 1'($urandom % 2);
            out_ready = ($urandom % 4) != 0;
         end
         cyc(1);
      end
      check("wait_state", m[0], st);
   endtask

   task automatic wait_pix(input int target);
      for (int i = 0; i < 2000 && n[0] != target; i++) cyc(1);
      check("wait_pix", n[0], target);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      #1 mon_en = 1'b1;
      cyc(2);
      reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      cyc(2);
      pulse();
      wait_state(2, 1000, 0);
      cyc(3);
      // downstream stall on pixel (10,5)
      pulse();
      wait_pix(150);
      out_ready = 1'b0;
      cyc(5);
      out_ready = 1'b1;
      wait_state(2, 1000, 0);
      cyc(3);
      // reset mid-frame at pixel (15,8), then a full frame
      pulse();
      wait_pix(239);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      cyc(3);
      pulse();
      wait_state(2, 1000, 0);
      cyc(3);
      // start pulses in RUN and in DONE must be ignored
      pulse();
      wait_pix(100);
      pulse();
      wait_state(2, 1000, 0);
      pulse();
      cyc(5);
      // random source bubbles and downstream stalls
      pulse();
      wait_state(2, 6000, 1);
      in_valid = 1'b1; out_ready = 1'b1;
      cyc(20);
      check("frames_a", done_cnt[0], 5);
      check("frames_b", done_cnt[1], 5);
      check("frames_c_min", done_cnt[2] >= 5, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
